// File: rtl/usb_fs_out_pe.sv
// rtl/usb_fs_out_pe.sv - USB full-speed OUT/SETUP protocol engine with per-endpoint packet buffers
module usb_fs_out_pe #(
    parameter int NUM_OUT_EPS         = 11,
    parameter int MAX_OUT_PACKET_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] reset_ep,
    input  logic [6:0]             dev_addr,

    output logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    output logic [7:0]             out_ep_data,
    output logic [NUM_OUT_EPS-1:0] out_ep_setup,
    output logic [NUM_OUT_EPS-1:0] out_ep_acked,
    input  logic [NUM_OUT_EPS-1:0] out_ep_stall,

    input  logic                   rx_pkt_start,
    input  logic                   rx_pkt_end,
    input  logic                   rx_pkt_valid,
    input  logic [3:0]             rx_pid,
    input  logic [6:0]             rx_addr,
    input  logic [3:0]             rx_endp,
    input  logic                   rx_data_put,
    input  logic [7:0]             rx_data,

    output logic                   tx_pkt_start,
    output logic [3:0]             tx_pid,
    input  logic                   tx_pkt_end
);
    localparam int PW = $clog2(MAX_OUT_PACKET_SIZE + 1);
    localparam int MW = $clog2(NUM_OUT_EPS * MAX_OUT_PACKET_SIZE);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {EP_READY, EP_FULL, EP_STALL} ep_state_t;
    typedef enum logic [1:0] {IDLE, RCVD_TOKEN, DATA_END, WAIT_TX} xfer_state_t;

    ep_state_t   ep_state   [NUM_OUT_EPS];
    logic [PW-1:0] put_ptr  [NUM_OUT_EPS];
    logic [PW-1:0] get_ptr  [NUM_OUT_EPS];
    logic [NUM_OUT_EPS-1:0] data_toggle;

    xfer_state_t xfer_state;
    logic [3:0]  current_endp;
    logic        is_setup;
    logic        overflow;
    logic        data_valid_l;
    logic        data_pid_l;

    logic [7:0]    mem [NUM_OUT_EPS * MAX_OUT_PACKET_SIZE];
    logic          token_match;
    logic          cur_writable;
    logic          mem_we;
    logic [MW-1:0] wr_addr;
    logic [MW-1:0] rd_addr;
    logic [NUM_OUT_EPS-1:0] get_hit;
    logic          sel_valid;
    logic [3:0]    sel_ep;
    logic          setup_accept;

    assign token_match  = rx_pkt_end && rx_pkt_valid && (rx_addr == dev_addr)
                       && ({1'b0, rx_endp} < 5'(NUM_OUT_EPS));
    assign cur_writable = (ep_state[current_endp] == EP_READY) || is_setup;
    assign mem_we       = (xfer_state == RCVD_TOKEN) && rx_data_put && cur_writable
                       && (put_ptr[current_endp] < PW'(MAX_OUT_PACKET_SIZE));
    assign wr_addr      = MW'(current_endp) * MW'(MAX_OUT_PACKET_SIZE) + MW'(put_ptr[current_endp]);
    assign rd_addr      = MW'(sel_ep) * MW'(MAX_OUT_PACKET_SIZE) + MW'(get_ptr[sel_ep]);
    assign get_hit      = out_ep_data_get & out_ep_data_avail;
    assign setup_accept = (xfer_state == DATA_END) && data_valid_l && !overflow && is_setup;

    always_comb begin
        out_ep_data_avail = '0;
        sel_valid         = 1'b0;
        sel_ep            = '0;
        for (int i = 0; i < NUM_OUT_EPS; i++)
            out_ep_data_avail[i] = (ep_state[i] == EP_FULL) && (get_ptr[i] < put_ptr[i]);
        // Descending scan so the lowest requesting endpoint owns the read port.
        for (int i = NUM_OUT_EPS - 1; i >= 0; i--) begin
            if (get_hit[i]) begin
                sel_valid = 1'b1;
                sel_ep    = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_state   <= IDLE;
            current_endp <= '0;
            is_setup     <= 1'b0;
            overflow     <= 1'b0;
            data_valid_l <= 1'b0;
            data_pid_l   <= 1'b0;
            tx_pkt_start <= 1'b0;
            tx_pid       <= '0;
            out_ep_data  <= 8'h00;
            out_ep_setup <= '0;
            out_ep_acked <= '0;
            data_toggle  <= '0;
            for (int i = 0; i < NUM_OUT_EPS; i++) begin
                ep_state[i] <= EP_READY;
                put_ptr[i]  <= '0;
                get_ptr[i]  <= '0;
            end
        end else begin
            out_ep_acked <= '0;
            if (sel_valid)
                out_ep_data <= mem[rd_addr];
            for (int i = 0; i < NUM_OUT_EPS; i++) begin
                if (get_hit[i])
                    get_ptr[i] <= get_ptr[i] + 1'b1;
                if (ep_state[i] == EP_FULL && get_ptr[i] == put_ptr[i]) begin
                    ep_state[i] <= EP_READY;
                    get_ptr[i]  <= '0;
                end
            end

            case (xfer_state)
                IDLE: begin
                    if (token_match && (rx_pid == PID_OUT || rx_pid == PID_SETUP)) begin
                        xfer_state   <= RCVD_TOKEN;
                        current_endp <= rx_endp;
                        is_setup     <= (rx_pid == PID_SETUP);
                        overflow     <= 1'b0;
                        if (ep_state[rx_endp] == EP_READY || rx_pid == PID_SETUP)
                            put_ptr[rx_endp] <= '0;
                    end
                end
                RCVD_TOKEN: begin
                    if (rx_pkt_start)
                        overflow <= 1'b0;
                    if (rx_data_put && cur_writable) begin
                        if (mem_we)
                            put_ptr[current_endp] <= put_ptr[current_endp] + 1'b1;
                        else
                            overflow <= 1'b1;
                    end
                    if (rx_pkt_end) begin
                        if (rx_pid[1:0] == 2'b11) begin
                            xfer_state   <= DATA_END;
                            data_valid_l <= rx_pkt_valid;
                            data_pid_l   <= rx_pid[3];
                        end else begin
                            xfer_state <= IDLE;
                        end
                    end
                end
                DATA_END: begin
                    if (!data_valid_l || overflow) begin
                        xfer_state <= IDLE;
                    end else begin
                        xfer_state   <= WAIT_TX;
                        tx_pkt_start <= 1'b1;
                        if (is_setup) begin
                            tx_pid                      <= PID_ACK;
                            ep_state[current_endp]      <= EP_FULL;
                            get_ptr[current_endp]       <= '0;
                            data_toggle[current_endp]   <= 1'b1;
                            out_ep_setup[current_endp]  <= 1'b1;
                            out_ep_acked[current_endp]  <= 1'b1;
                        end else if (ep_state[current_endp] == EP_STALL) begin
                            tx_pid <= PID_STALL;
                        end else if (ep_state[current_endp] == EP_FULL) begin
                            tx_pid <= PID_NAK;
                        end else if (data_pid_l != data_toggle[current_endp]) begin
                            // Host missed our last ACK and resent; acknowledge and drop.
                            tx_pid <= PID_ACK;
                        end else begin
                            tx_pid                      <= PID_ACK;
                            ep_state[current_endp]      <= EP_FULL;
                            get_ptr[current_endp]       <= '0;
                            data_toggle[current_endp]   <= ~data_toggle[current_endp];
                            out_ep_setup[current_endp]  <= 1'b0;
                            out_ep_acked[current_endp]  <= 1'b1;
                        end
                    end
                end
                WAIT_TX: begin
                    tx_pkt_start <= 1'b0;
                    tx_pid       <= '0;
                    if (tx_pkt_end)
                        xfer_state <= IDLE;
                end
                default: xfer_state <= IDLE;
            endcase

            for (int i = 0; i < NUM_OUT_EPS; i++) begin
                if (out_ep_stall[i] && !(setup_accept && current_endp == 4'(i)))
                    ep_state[i] <= EP_STALL;
            end

            for (int i = 0; i < NUM_OUT_EPS; i++) begin
                if (reset_ep[i]) begin
                    ep_state[i]     <= EP_READY;
                    put_ptr[i]      <= '0;
                    get_ptr[i]      <= '0;
                    data_toggle[i]  <= 1'b0;
                    out_ep_setup[i] <= 1'b0;
                    out_ep_acked[i] <= 1'b0;
                    if (current_endp == 4'(i) && xfer_state != IDLE) begin
                        xfer_state   <= IDLE;
                        tx_pkt_start <= 1'b0;
                        tx_pid       <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_fs_out_pe.sv
// tb/tb_usb_fs_out_pe.sv - directed self-checking bench for usb_fs_out_pe
module tb_usb_fs_out_pe;
    localparam int N = 11;
    localparam logic [6:0] ADDR = 7'd5;
    localparam logic [3:0] OUT = 4'b0001, SETUP = 4'b1101, D0 = 4'b0011, D1 = 4'b1011;
    localparam logic [3:0] ACK = 4'b0010, NAK = 4'b1010, STL = 4'b1110;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] reset_ep = '0;
    logic [6:0]   dev_addr = ADDR;
    logic [N-1:0] out_ep_data_avail;
    logic [N-1:0] out_ep_data_get = '0;
    logic [7:0]   out_ep_data;
    logic [N-1:0] out_ep_setup;
    logic [N-1:0] out_ep_acked;
    logic [N-1:0] out_ep_stall = '0;
    logic         rx_pkt_start = 1'b0, rx_pkt_end = 1'b0, rx_pkt_valid = 1'b0;
    logic [3:0]   rx_pid = '0;
    logic [6:0]   rx_addr = '0;
    logic [3:0]   rx_endp = '0;
    logic         rx_data_put = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         tx_pkt_start;
    logic [3:0]   tx_pid;
    logic         tx_pkt_end = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] pay [0:63];

    usb_fs_out_pe #(.NUM_OUT_EPS(N), .MAX_OUT_PACKET_SIZE(32)) dut (
        .clk(clk), .reset(reset), .reset_ep(reset_ep), .dev_addr(dev_addr),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_data_get(out_ep_data_get),
        .out_ep_data(out_ep_data), .out_ep_setup(out_ep_setup), .out_ep_acked(out_ep_acked),
        .out_ep_stall(out_ep_stall), .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end),
        .rx_pkt_valid(rx_pkt_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
        .rx_data_put(rx_data_put), .rx_data(rx_data), .tx_pkt_start(tx_pkt_start),
        .tx_pid(tx_pid), .tx_pkt_end(tx_pkt_end)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) pay[i] = base + 8'(i);
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
        rx_pkt_start = 1'b1; tick; rx_pkt_start = 1'b0;
        rx_pid = pid; rx_addr = addr; rx_endp = ep; rx_pkt_valid = 1'b1; rx_pkt_end = 1'b1;
        tick;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int last);
        for (int i = first; i < last; i++) begin
            rx_data = pay[i]; rx_data_put = 1'b1; tick; rx_data_put = 1'b0;
        end
    endtask

    task automatic end_data(input logic [3:0] pid, input logic valid);
        rx_pid = pid; rx_pkt_valid = valid; rx_pkt_end = 1'b1;
        tick;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
    endtask

    task automatic await_hs(output logic seen, output logic [3:0] pid, output logic [N-1:0] acked);
        seen = 1'b0; pid = '0; acked = '0;
        for (int c = 0; c < 8 && !seen; c++) begin
            acked = acked | out_ep_acked;
            if (tx_pkt_start) begin
                seen = 1'b1; pid = tx_pid;
            end else begin
                tick;
            end
        end
        if (seen) begin
            tx_pkt_end = 1'b1; tick; tx_pkt_end = 1'b0;
        end
    endtask

    task automatic xfer(input string tag, input logic [3:0] tok, input logic [3:0] ep,
                        input logic [3:0] dpid, input int len, input logic valid,
                        input logic exp_seen, input logic [3:0] exp_pid, input logic exp_ack);
        logic seen;
        logic [3:0] pid;
        logic [N-1:0] acked;
        send_token(tok, ADDR, ep);
        rx_pkt_start = 1'b1; tick; rx_pkt_start = 1'b0;
        send_bytes(0, len);
        end_data(dpid, valid);
        await_hs(seen, pid, acked);
        check({tag, "_hs"}, 32'(seen), 32'(exp_seen));
        check({tag, "_pid"}, 32'(pid), 32'(exp_pid));
        check({tag, "_acked"}, 32'(acked[ep]), 32'(exp_ack));
    endtask

    task automatic get_byte(input string tag, input int ep, input logic [7:0] exp);
        out_ep_data_get[ep] = 1'b1; tick; out_ep_data_get = '0;
        check(tag, 32'(out_ep_data), 32'(exp));
    endtask

    initial begin
        logic seen;
        logic [3:0] pid;
        logic [N-1:0] acked;

        repeat (3) tick;
        check("rst_avail", 32'(out_ep_data_avail), 0);
        check("rst_setup", 32'(out_ep_setup), 0);
        check("rst_acked", 32'(out_ep_acked), 0);
        check("rst_tx", {27'd0, tx_pkt_start, tx_pid}, 0);
        check("rst_data", 32'(out_ep_data), 0);
        reset = 1'b0;
        tick;

        // Basic OUT: 4 bytes, ACK, drain, endpoint back to READY
        fill(8'hA1, 4);
        xfer("ep1_out", OUT, 4'd1, D0, 4, 1'b1, 1'b1, ACK, 1'b1);
        check("ep1_avail", 32'(out_ep_data_avail[1]), 1);
        check("ep1_setup", 32'(out_ep_setup[1]), 0);
        check("tx_pid_idle", 32'(tx_pid), 0);
        for (int i = 0; i < 4; i++) get_byte("ep1_get", 1, 8'hA1 + 8'(i));
        check("ep1_drained", 32'(out_ep_data_avail[1]), 0);
        tick;

        // Repeated DATA0: ACK but discarded
        fill(8'hB1, 2);
        xfer("ep1_dup", OUT, 4'd1, D0, 2, 1'b1, 1'b1, ACK, 1'b0);
        check("ep1_dup_avail", 32'(out_ep_data_avail[1]), 0);

        // NAK while FULL, then STALL, then SETUP clears it
        fill(8'hC1, 3);
        xfer("ep2_out", OUT, 4'd2, D0, 3, 1'b1, 1'b1, ACK, 1'b1);
        get_byte("ep2_c1", 2, 8'hC1);
        fill(8'hD1, 1);
        xfer("ep2_nak", OUT, 4'd2, D1, 1, 1'b1, 1'b1, NAK, 1'b0);
        check("ep2_nak_avail", 32'(out_ep_data_avail[2]), 1);
        get_byte("ep2_c2", 2, 8'hC2);
        out_ep_stall[2] = 1'b1; tick;
        xfer("ep2_stall", OUT, 4'd2, D1, 1, 1'b1, 1'b1, STL, 1'b0);
        check("ep2_stall_avail", 32'(out_ep_data_avail[2]), 0);
        out_ep_stall[2] = 1'b0; tick;
        fill(8'hE0, 8);
        xfer("ep2_setup", SETUP, 4'd2, D0, 8, 1'b1, 1'b1, ACK, 1'b1);
        check("ep2_setup_flag", 32'(out_ep_setup[2]), 1);
        for (int i = 0; i < 8; i++) get_byte("ep2_setup_get", 2, 8'hE0 + 8'(i));
        tick;
        fill(8'hF0, 1);
        xfer("ep2_after_setup", OUT, 4'd2, D1, 1, 1'b1, 1'b1, ACK, 1'b1);
        check("ep2_setup_clr", 32'(out_ep_setup[2]), 0);
        get_byte("ep2_f0", 2, 8'hF0);
        tick;

        // Overflow, exact-max, invalid CRC, wrong address, zero length
        fill(8'h00, 33);
        xfer("ep3_ovf", OUT, 4'd3, D0, 33, 1'b1, 1'b0, 4'd0, 1'b0);
        check("ep3_ovf_avail", 32'(out_ep_data_avail[3]), 0);
        fill(8'h40, 32);
        xfer("ep3_max", OUT, 4'd3, D0, 32, 1'b1, 1'b1, ACK, 1'b1);
        for (int i = 0; i < 32; i++) get_byte("ep3_get", 3, 8'h40 + 8'(i));
        check("ep3_drained", 32'(out_ep_data_avail[3]), 0);
        fill(8'h11, 2);
        xfer("ep4_bad_crc", OUT, 4'd4, D0, 2, 1'b0, 1'b0, 4'd0, 1'b0);
        check("ep4_bad_avail", 32'(out_ep_data_avail[4]), 0);
        send_token(OUT, 7'd6, 4'd4);
        rx_pkt_start = 1'b1; tick; rx_pkt_start = 1'b0;
        send_bytes(0, 2);
        end_data(D0, 1'b1);
        await_hs(seen, pid, acked);
        check("wrong_addr_hs", 32'(seen), 0);
        xfer("ep5_zlp", OUT, 4'd5, D0, 0, 1'b1, 1'b1, ACK, 1'b1);
        check("ep5_zlp_avail", 32'(out_ep_data_avail[5]), 0);
        tick;
        fill(8'h55, 1);
        xfer("ep5_next", OUT, 4'd5, D1, 1, 1'b1, 1'b1, ACK, 1'b1);
        get_byte("ep5_get", 5, 8'h55);

        // reset_ep mid-packet aborts transfer and resets toggle
        fill(8'h60, 4);
        send_token(OUT, ADDR, 4'd1);
        rx_pkt_start = 1'b1; tick; rx_pkt_start = 1'b0;
        send_bytes(0, 2);
        reset_ep[1] = 1'b1; tick; reset_ep = '0;
        send_bytes(2, 4);
        end_data(D1, 1'b1);
        await_hs(seen, pid, acked);
        check("rst_ep_hs", 32'(seen), 0);
        check("rst_ep_avail", 32'(out_ep_data_avail[1]), 0);
        fill(8'h77, 1);
        xfer("ep1_after_rst", OUT, 4'd1, D0, 1, 1'b1, 1'b1, ACK, 1'b1);
        get_byte("ep1_after_rst_get", 1, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
